// File: rtl/alu_sequencer.sv
// alu_sequencer: walks the operand-select code (inner loop) and ALU opcode
// (outer loop) through every combination, issues one request per step,
// captures each result over REQ/ACK, holds it for a dwell period or until a
// manual STEP, and keeps a rotate-xor checksum of all captured results.
module alu_sequencer #(
    parameter int unsigned DWELL   = 50_000_000,
    parameter int unsigned TMO     = 16,
    parameter int unsigned LAST_OP = 7
) (
    input  logic        ALU_SEQ_CLK_xi,
    input  logic        ALU_SEQ_RST_xi,
    input  logic        ALU_SEQ_START_xi,
    input  logic        ALU_SEQ_MODE_xi,
    input  logic        ALU_SEQ_STEP_xi,
    output logic [2:0]  ALU_SEQ_SW_xo,
    output logic [2:0]  ALU_SEQ_OP_xo,
    output logic        ALU_SEQ_REQ_xo,
    input  logic        ALU_SEQ_ACK_xi,
    input  logic [31:0] ALU_SEQ_F_xi,
    output logic [31:0] ALU_SEQ_RES_xo,
    output logic [31:0] ALU_SEQ_SUM_xo,
    output logic        ALU_SEQ_BUSY_xo,
    output logic        ALU_SEQ_DONE_xo,
    output logic        ALU_SEQ_ERR_xo
);

    // Dwell counter spans 0..DWELL-1, timeout counter spans 0..TMO-1.
    localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned TMO_W = (TMO > 1) ? $clog2(TMO) : 1;

    localparam logic [DW_W-1:0]  DW_LAST   = DW_W'(DWELL - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO - 1);
    localparam logic [2:0]       OP_LAST   = 3'(LAST_OP);
    localparam logic [2:0]       SW_LAST   = 3'd7;
    localparam logic [31:0]      ERR_VALUE = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [2:0]        r_sw;
    logic [2:0]        r_op;
    logic              r_req;
    logic [31:0]       r_res;
    logic [31:0]       r_sum;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DW_W-1:0]   r_dwell;
    logic [TMO_W-1:0]  r_tmo;

    logic              w_ack;
    logic              w_tmo_hit;
    logic              w_advance;
    logic              w_last_step;
    logic [31:0]       w_sum_next;

    // An ACK only counts while a request is outstanding.
    assign w_ack       = r_req & ALU_SEQ_ACK_xi;
    assign w_tmo_hit   = (r_tmo == TMO_LAST);
    assign w_last_step = (r_sw == SW_LAST) && (r_op == OP_LAST);
    assign w_sum_next  = {r_sum[30:0], r_sum[31]} ^ ALU_SEQ_F_xi;

    // MODE is looked at every HOLD cycle, so flipping it mid-hold acts at once.
    assign w_advance = (r_state == S_HOLD) &&
                       (ALU_SEQ_MODE_xi ? ALU_SEQ_STEP_xi : (r_dwell == DW_LAST));

    // Sweep state machine with all outputs registered.
    always_ff @(posedge ALU_SEQ_CLK_xi or posedge ALU_SEQ_RST_xi) begin
        if (ALU_SEQ_RST_xi) begin
            r_state <= S_IDLE;
            r_sw    <= 3'd0;
            r_op    <= 3'd0;
            r_req   <= 1'b0;
            r_res   <= 32'd0;
            r_sum   <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_dwell <= '0;
            r_tmo   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (ALU_SEQ_START_xi) begin
                        r_sw    <= 3'd0;
                        r_op    <= 3'd0;
                        r_sum   <= 32'd0;
                        r_res   <= 32'd0;
                        r_err   <= 1'b0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_req   <= 1'b1;
                        r_tmo   <= '0;
                        r_dwell <= '0;
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (w_ack) begin
                        // Result captured: drop REQ on this same edge.
                        r_res   <= ALU_SEQ_F_xi;
                        r_sum   <= w_sum_next;
                        r_req   <= 1'b0;
                        r_dwell <= '0;
                        r_state <= S_HOLD;
                    end else if (w_tmo_hit) begin
                        // ALU never answered: abort the sweep, checksum untouched.
                        r_err   <= 1'b1;
                        r_res   <= ERR_VALUE;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                S_HOLD: begin
                    if (w_advance) begin
                        if (w_last_step) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // SW is the inner loop; it wraps into the next opcode.
                            if (r_sw == SW_LAST) begin
                                r_sw <= 3'd0;
                                r_op <= r_op + 3'd1;
                            end else begin
                                r_sw <= r_sw + 3'd1;
                            end
                            r_req   <= 1'b1;
                            r_tmo   <= '0;
                            r_state <= S_ISSUE;
                        end
                    end else if (!ALU_SEQ_MODE_xi) begin
                        // Dwell only accumulates while in auto mode.
                        r_dwell <= r_dwell + DW_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ALU_SEQ_SW_xo   = r_sw;
    assign ALU_SEQ_OP_xo   = r_op;
    assign ALU_SEQ_REQ_xo  = r_req;
    assign ALU_SEQ_RES_xo  = r_res;
    assign ALU_SEQ_SUM_xo  = r_sum;
    assign ALU_SEQ_BUSY_xo = r_busy;
    assign ALU_SEQ_DONE_xo = r_done;
    assign ALU_SEQ_ERR_xo  = r_err;

endmodule
